// File: rtl/mmc1_serial_banker.sv
// mmc1_serial_banker: MMC1-style serial register loader with PRG/CHR bank translation and cycle IRQ
module mmc1_serial_banker #(
    parameter int SHIFT_BITS = 5,
    parameter int PRG_BANK_BITS = 4,
    parameter int CHR_BANK_BITS = 5,
    parameter int IRQ_CNT_BITS = 30,
    parameter logic [IRQ_CNT_BITS-1:0] IRQ_MATCH = 30'h2800000,
    parameter int IRQ_EN = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ce,
    input  logic [15:0] prg_ain,
    input  logic        prg_write,
    input  logic [7:0]  prg_din,
    input  logic [13:0] chr_ain,
    output logic [21:0] prg_aout,
    output logic        prg_allow,
    output logic [21:0] chr_aout,
    output logic        vram_a10,
    output logic        vram_ce,
    output logic        irq,
    output logic        reg_commit,
    output logic [1:0]  commit_idx
);
    localparam logic [SHIFT_BITS-1:0] SENT = {1'b1, {(SHIFT_BITS-1){1'b0}}};

    logic [SHIFT_BITS-1:0]    shift, shift_in;
    logic [4:0]               control;
    logic [CHR_BANK_BITS-1:0] chr0, chr1, chrsel;
    logic [PRG_BANK_BITS:0]   prg;
    logic [PRG_BANK_BITS-1:0] pb, prgsel;
    logic [IRQ_CNT_BITS-1:0]  cnt, cnt_nx;
    logic                     guard, accept, load, ram_window;
    logic                     unused;

    assign accept   = ce & prg_write & prg_ain[15] & ~guard;
    assign shift_in = {prg_din[0], shift[SHIFT_BITS-1:1]};
    assign load     = accept & ~prg_din[7] & shift[0];
    assign unused   = ^prg_din[6:1];

    // serial port: write filter, shift register, register loads and commit strobe
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shift      <= SENT;
            control    <= 5'b01100;
            chr0       <= '0;
            chr1       <= '0;
            prg        <= '0;
            guard      <= 1'b0;
            reg_commit <= 1'b0;
            commit_idx <= 2'd0;
        end else begin
            reg_commit <= load;
            if (ce) guard <= accept | (guard & prg_write);
            if (accept) begin
                if (prg_din[7]) begin
                    shift        <= SENT;
                    control[3:2] <= 2'b11;
                end else if (shift[0]) begin
                    shift      <= SENT;
                    commit_idx <= prg_ain[14:13];
                    case (prg_ain[14:13])
                        2'd0:    control <= shift_in[4:0];
                        2'd1:    chr0    <= shift_in[CHR_BANK_BITS-1:0];
                        2'd2:    chr1    <= shift_in[CHR_BANK_BITS-1:0];
                        default: prg     <= shift_in[PRG_BANK_BITS:0];
                    endcase
                end else begin
                    shift <= shift_in;
                end
            end
        end
    end

    assign cnt_nx = (cnt == IRQ_MATCH) ? cnt : cnt + 1'b1;

    // saturating cycle counter; the chr0 top bit acknowledges and holds it cleared
    always_ff @(posedge clk) begin
        if (!rst_n || IRQ_EN == 0) begin
            cnt <= '0;
            irq <= 1'b0;
        end else if (ce) begin
            if (chr0[CHR_BANK_BITS-1]) begin
                cnt <= '0;
                irq <= 1'b0;
            end else begin
                cnt <= cnt_nx;
                if (cnt_nx == IRQ_MATCH) irq <= 1'b1;
            end
        end
    end

    assign pb         = prg[PRG_BANK_BITS-1:0];
    assign ram_window = prg_ain[15:13] == 3'b011;

    // bank selection and address translation, purely combinational
    always_comb begin
        prgsel = control[3] ? (control[2] ? (prg_ain[14] ? '1 : pb) : (prg_ain[14] ? pb : '0))
                            : ((pb & ~PRG_BANK_BITS'(1)) | PRG_BANK_BITS'(prg_ain[14]));
        chrsel = control[4] ? (chr_ain[12] ? chr1 : chr0)
                            : ((chr0 & ~CHR_BANK_BITS'(1)) | CHR_BANK_BITS'(chr_ain[12]));
        prg_aout  = ram_window ? {9'b111100000, prg_ain[12:0]} : 22'({prgsel, prg_ain[13:0]});
        prg_allow = (prg_ain[15] & ~prg_write) | (ram_window & ~prg[PRG_BANK_BITS]);
        chr_aout  = {4'b1000, 18'({chrsel, chr_ain[11:0]})};
        vram_a10  = control[1] ? (control[0] ? chr_ain[11] : chr_ain[10]) : control[0];
        vram_ce   = chr_ain[13];
    end
endmodule

// File: tb/tb_mmc1_serial_banker.sv
// tb_mmc1_serial_banker: directed self-checking bench for mmc1_serial_banker
module tb_mmc1_serial_banker;
    logic        clk = 1'b0, rst_n = 1'b0, ce = 1'b0, prg_write = 1'b0;
    logic [15:0] prg_ain = 16'h0000;
    logic [7:0]  prg_din = 8'h00;
    logic [13:0] chr_ain = 14'h0000;
    logic [21:0] prg_aout, chr_aout;
    logic        prg_allow, vram_a10, vram_ce, irq, reg_commit;
    logic [1:0]  commit_idx;
    logic [1:0]  last_idx = 2'd0;
    int          checks = 0, errors = 0, commits = 0;

    mmc1_serial_banker #(.IRQ_MATCH(30'd16)) dut (
        .clk(clk), .rst_n(rst_n), .ce(ce), .prg_ain(prg_ain), .prg_write(prg_write),
        .prg_din(prg_din), .chr_ain(chr_ain), .prg_aout(prg_aout), .prg_allow(prg_allow),
        .chr_aout(chr_aout), .vram_a10(vram_a10), .vram_ce(vram_ce), .irq(irq),
        .reg_commit(reg_commit), .commit_idx(commit_idx)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (reg_commit) begin
            commits++;
            last_idx = commit_idx;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        ce = 1'b1;
        prg_write = 1'b1;
        prg_ain = a;
        prg_din = d;
        step();
        prg_write = 1'b0;
        prg_ain = 16'h0000;
        step();
        ce = 1'b0;
    endtask

    task automatic load(input logic [1:0] idx, input logic [4:0] v);
        for (int i = 0; i < 5; i++) wr(16'h8000 | (16'(idx) << 13), {7'b0, v[i]});
    endtask

    task automatic ces(input int n);
        ce = 1'b1;
        prg_write = 1'b0;
        repeat (n) step();
        ce = 1'b0;
    endtask

    task automatic rd(input logic [15:0] a);
        prg_write = 1'b0;
        prg_ain = a;
        #1;
    endtask

    initial begin
        step();
        step();
        chk("rst_irq", 32'(irq), 0);
        chk("rst_commit", 32'(reg_commit), 0);
        chk("rst_idx", 32'(commit_idx), 0);
        chk("rst_shift", 32'(dut.shift), 32'h10);
        rd(16'h8000);
        chk("rst_prg8000", 32'(prg_aout), 32'h000000);
        chk("rst_allow", 32'(prg_allow), 1);
        rd(16'hC000);
        chk("rst_prgC000", 32'(prg_aout), 32'h03C000);
        chk_chr: begin
            chr_ain = 14'h1000;
            #1;
            chk("rst_chr", 32'(chr_aout), 32'h201000);
            chk("rst_a10", 32'(vram_a10), 0);
        end
        rst_n = 1'b1;
        ce = 1'b0;
        prg_write = 1'b1;
        prg_ain = 16'hE000;
        prg_din = 8'h01;
        step();
        prg_write = 1'b0;
        chk("ce_gate_shift", 32'(dut.shift), 32'h10);

        commits = 0;
        load(2'd3, 5'h01);
        chk("prg_commits", 32'(commits), 1);
        chk("prg_idx", 32'(last_idx), 3);
        chk("commit_low", 32'(reg_commit), 0);
        rd(16'h8000);
        chk("prg_8000", 32'(prg_aout), 32'h004000);

        ce = 1'b1;
        prg_write = 1'b1;
        prg_ain = 16'hE000;
        prg_din = 8'h01;
        step();
        step();
        prg_write = 1'b0;
        step();
        ce = 1'b0;
        chk("b2b_shift", 32'(dut.shift), 32'h18);
        wr(16'h8000, 8'h80);
        chk("rstwr_shift", 32'(dut.shift), 32'h10);

        commits = 0;
        load(2'd0, 5'h00);
        chk("ctl_commits", 32'(commits), 1);
        chk("ctl_idx", 32'(last_idx), 0);
        rd(16'hC000);
        chk("mode0_C000", 32'(prg_aout), 32'h004000);
        rd(16'h8000);
        chk("mode0_8000", 32'(prg_aout), 32'h000000);
        commits = 0;
        for (int i = 0; i < 3; i++) wr(16'h8000, 8'h01);
        wr(16'h8000, 8'h80);
        chk("abort3_shift", 32'(dut.shift), 32'h10);
        rd(16'hC000);
        chk("abort3_ctl", 32'(prg_aout), 32'h03C000);
        for (int i = 0; i < 4; i++) wr(16'hE000, 8'h01);
        wr(16'hE000, 8'h81);
        chk("abort_final_nocommit", 32'(commits), 0);
        load(2'd3, 5'h02);
        chk("after_abort_commits", 32'(commits), 1);
        rd(16'h8000);
        chk("after_abort_8000", 32'(prg_aout), 32'h008000);

        load(2'd3, 5'h10);
        rd(16'h6000);
        chk("ram_dis_allow", 32'(prg_allow), 0);
        chk("ram_dis_addr", 32'(prg_aout), 32'h3C0000);
        load(2'd3, 5'h00);
        rd(16'h6000);
        chk("ram_en_allow", 32'(prg_allow), 1);
        chk("ram_en_addr", 32'(prg_aout), 32'h3C0000);
        prg_ain = 16'h8000;
        prg_write = 1'b1;
        #1;
        chk("rom_wr_allow", 32'(prg_allow), 0);
        rd(16'h8000);
        chk("rom_rd_allow", 32'(prg_allow), 1);

        load(2'd0, 5'b10010);
        load(2'd1, 5'd5);
        load(2'd2, 5'd9);
        chr_ain = 14'h1ABC;
        #1;
        chk("chr4k_hi", 32'(chr_aout), 32'h209ABC);
        chr_ain = 14'h0ABC;
        #1;
        chk("chr4k_lo", 32'(chr_aout), 32'h205ABC);
        chr_ain = 14'h0400;
        #1;
        chk("mirror_a10_1", 32'(vram_a10), 1);
        chr_ain = 14'h0000;
        #1;
        chk("mirror_a10_0", 32'(vram_a10), 0);
        chr_ain = 14'h2000;
        #1;
        chk("vram_ce", 32'(vram_ce), 1);
        load(2'd0, 5'b01111);
        chr_ain = 14'h0800;
        #1;
        chk("mirror3_a11", 32'(vram_a10), 1);
        chr_ain = 14'h0400;
        #1;
        chk("mirror3_a10", 32'(vram_a10), 0);
        chr_ain = 14'h0ABC;
        #1;
        chk("chr8k_lo", 32'(chr_aout), 32'h204ABC);

        load(2'd1, 5'h10);
        chk("ack_irq", 32'(irq), 0);
        chk("ack_cnt", 32'(dut.cnt), 0);
        load(2'd1, 5'h00);
        chk("cnt_start", 32'(dut.cnt), 1);
        ces(14);
        chk("irq_pre", 32'(irq), 0);
        chk("cnt_15", 32'(dut.cnt), 15);
        step();
        step();
        chk("ce_off_hold", 32'(dut.cnt), 15);
        ces(1);
        chk("irq_rise", 32'(irq), 1);
        chk("cnt_16", 32'(dut.cnt), 16);
        ces(3);
        chk("cnt_sat", 32'(dut.cnt), 16);
        chk("irq_sticky", 32'(irq), 1);
        load(2'd1, 5'h10);
        chk("irq_clear", 32'(irq), 0);
        chk("cnt_clear", 32'(dut.cnt), 0);

        wr(16'hE000, 8'h01);
        wr(16'hE000, 8'h01);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("midrst_shift", 32'(dut.shift), 32'h10);
        rd(16'hC000);
        chk("midrst_ctl", 32'(prg_aout), 32'h03C000);
        commits = 0;
        load(2'd3, 5'h01);
        chk("midrst_commits", 32'(commits), 1);
        rd(16'h8000);
        chk("midrst_8000", 32'(prg_aout), 32'h004000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
